// File: rtl/read_ptr_empty_logic_if.sv
// Read-side FIFO control bundle: pop request and incoming write pointer in,
// read pointer (binary and Gray) and read-domain status flags out.
interface read_ptr_empty_logic_if #(
  parameter int PTR_W = 4
);
  logic             rd_en;
  logic [PTR_W-1:0] write_ptr_gray;
  logic [PTR_W-1:0] read_ptr;
  logic [PTR_W-1:0] read_ptr_gray;
  logic             empty;
  logic             almost_empty;
  logic [PTR_W-1:0] rd_count;
  logic             rd_valid;
  logic             underflow;

  modport master (
    output rd_en, write_ptr_gray,
    input  read_ptr, read_ptr_gray, empty, almost_empty, rd_count, rd_valid, underflow
  );

  modport slave (
    input  rd_en, write_ptr_gray,
    output read_ptr, read_ptr_gray, empty, almost_empty, rd_count, rd_valid, underflow
  );
endinterface

// File: rtl/read_ptr_empty_logic.sv
// Async FIFO read-side control: brings the Gray write pointer into read_clk,
// owns the read pointer and derives empty / almost_empty / count / valid / underflow.
module read_ptr_empty_logic #(
  parameter int PTR_W     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                        read_clk,
  input  logic                        rst,
  read_ptr_empty_logic_if.slave       rd_if
);

  localparam logic [PTR_W:0] AE_LIMIT = (PTR_W+1)'(AE_THRESH);

  logic [PTR_W-1:0] sync1_q, sync1_d;
  logic [PTR_W-1:0] sync2_q, sync2_d;
  logic [PTR_W-1:0] read_ptr_q, read_ptr_d;
  logic [PTR_W-1:0] read_ptr_gray_q, read_ptr_gray_d;
  logic             rd_valid_q, rd_valid_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] wptr_bin;
  logic [PTR_W-1:0] rd_count;
  logic             empty;
  logic             almost_empty;
  logic             pop;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // NOTE: every signal gets a value at the top of the block, so no path can leave one unassigned and infer a latch.
  always_comb begin
    sync1_d         = rd_if.write_ptr_gray;
    sync2_d         = sync1_q;
    wptr_bin        = gray2bin(sync2_q);
    empty           = (read_ptr_q == wptr_bin);
    rd_count        = wptr_bin - read_ptr_q;
    almost_empty    = ({1'b0, rd_count} <= AE_LIMIT);
    pop             = rd_if.rd_en && !empty;

    read_ptr_d      = read_ptr_q;
    if (pop) begin
      read_ptr_d = read_ptr_q + PTR_W'(1);
    end
    // Gray form comes from the next binary value so it can leave a flop directly.
    read_ptr_gray_d = read_ptr_d ^ (read_ptr_d >> 1);
    rd_valid_d      = pop;
    underflow_d     = underflow_q | (rd_if.rd_en & empty);
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which is what makes the sync chain two stages deep.
  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      sync1_q         <= '0;
      sync2_q         <= '0;
      read_ptr_q      <= '0;
      read_ptr_gray_q <= '0;
      rd_valid_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      read_ptr_q      <= read_ptr_d;
      read_ptr_gray_q <= read_ptr_gray_d;
      rd_valid_q      <= rd_valid_d;
      underflow_q     <= underflow_d;
    end
  end

  assign rd_if.read_ptr      = read_ptr_q;
  assign rd_if.read_ptr_gray = read_ptr_gray_q;
  assign rd_if.empty         = empty;
  assign rd_if.almost_empty  = almost_empty;
  assign rd_if.rd_count      = rd_count;
  assign rd_if.rd_valid      = rd_valid_q;
  assign rd_if.underflow     = underflow_q;

endmodule

// File: tb/tb_read_ptr_empty_logic.sv
// Bench for read_ptr_empty_logic: directed scenarios then random traffic, all
// compared against an occupancy model built from unbounded write/read totals.
module tb_read_ptr_empty_logic;

  localparam int PTR_W = 4;
  localparam int DEPTH = 1 << PTR_W;
  localparam int AE    = 2;

  logic read_clk = 1'b0;
  logic rst      = 1'b1;

  read_ptr_empty_logic_if #(.PTR_W(PTR_W)) rd_if ();

  read_ptr_empty_logic #(.PTR_W(PTR_W), .AE_THRESH(AE)) dut (
    .read_clk (read_clk),
    .rst      (rst),
    .rd_if    (rd_if.slave)
  );

  always #5 read_clk = ~read_clk;

  int checks   = 0;
  int failures = 0;

  // Model: totals never wrap; the read side sees the write total sampled one edge before the latest one.
  int wr_total   = 0;
  int rd_total   = 0;
  int wr_hist[$];
  bit m_rd_valid = 1'b0;
  bit m_underflow = 1'b0;

  function automatic int to_gray(input int v);
    int x;
    x = v % DEPTH;
    return x ^ (x >> 1);
  endfunction

  function automatic int seen_total();
    return (wr_hist.size() >= 2) ? wr_hist[1] : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int avail;
    avail = seen_total() - rd_total;
    chk("read_ptr",      32'(rd_if.read_ptr),      32'(rd_total % DEPTH));
    chk("read_ptr_gray", 32'(rd_if.read_ptr_gray), 32'(to_gray(rd_total)));
    chk("rd_count",      32'(rd_if.rd_count),      32'(avail));
    chk("empty",         32'(rd_if.empty),         32'(avail == 0));
    chk("almost_empty",  32'(rd_if.almost_empty),  32'(avail <= AE));
    chk("rd_valid",      32'(rd_if.rd_valid),      32'(m_rd_valid));
    chk("underflow",     32'(rd_if.underflow),     32'(m_underflow));
  endtask

  task automatic model_reset();
    wr_hist.delete();
    wr_total    = 0;
    rd_total    = 0;
    m_rd_valid  = 1'b0;
    m_underflow = 1'b0;
    rd_if.write_ptr_gray = '0;
  endtask

  // Called at a negedge: apply inputs, advance one read_clk edge, check at the next negedge.
  task automatic step(input bit en, input bit wr);
    int avail;
    rd_if.rd_en = en;
    if (wr && (wr_total - rd_total) < DEPTH - 1) begin
      wr_total++;
      rd_if.write_ptr_gray = PTR_W'(to_gray(wr_total));
    end
    @(posedge read_clk);
    avail = seen_total() - rd_total;
    m_rd_valid = en && (avail > 0);
    if (en && avail == 0) m_underflow = 1'b1;
    if (m_rd_valid) rd_total++;
    wr_hist.push_front(wr_total);
    if (wr_hist.size() > 4) void'(wr_hist.pop_back());
    @(negedge read_clk);
    check_all();
  endtask

  initial begin
    rd_if.rd_en          = 1'b0;
    rd_if.write_ptr_gray = '0;
    model_reset();
    #1 check_all();
    @(negedge read_clk);
    @(negedge read_clk);
    rst = 1'b0;
    check_all();

    // Sync latency, single pop, then underflow on an empty FIFO.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Full lap of writes so the write pointer wraps to 0, then drain through the read wrap.
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Reset arriving mid-cycle while a rd_valid pulse is in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    rd_if.rd_en = 1'b0;
    #1 check_all();
    @(posedge read_clk);
    @(negedge read_clk);
    rst = 1'b0;
    check_all();

    // Burst: five entries, rd_en held past the last one.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
        rd_if.rd_en = 1'b0;
        #1 check_all();
        @(negedge read_clk);
        rst = 1'b0;
      end
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/read_ptr_empty_logic.md
Name: read_ptr_empty_logic

Overview:
- Read-side control for the asynchronous FIFO; the read-domain counterpart of the write-side full-flag logic.
- Synchronises the Gray-coded write pointer into the read clock domain and decodes it to binary.
- Owns the binary read pointer and publishes its Gray form for the write side.
- Generates empty, almost-empty, fill count, read-valid and a sticky underflow flag.

Parameters:
PTR_W, 4, pointer width in bits; memory depth is 2^PTR_W, usable capacity is 2^PTR_W-1 (one slot sacrificed, matching full = wr+1 == rd).
AE_THRESH, 2, almost_empty asserts when rd_count <= AE_THRESH.

Ports:
read_clk  input  1  read-domain clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
rd_en  input  1  pop request.
write_ptr_gray  input  PTR_W  Gray-coded write pointer from the write domain (asynchronous to read_clk).
read_ptr  output  PTR_W  registered binary read pointer; memory read address.
read_ptr_gray  output  PTR_W  registered Gray form of read_ptr, sent to the write-side synchroniser.
empty  output  1  FIFO empty as seen from the read domain.
almost_empty  output  1  rd_count <= AE_THRESH.
rd_count  output  PTR_W  entries available to the reader.
rd_valid  output  1  one-cycle pulse: memory data for the accepted pop is valid.
underflow  output  1  sticky; set by a pop attempted while empty.

Behaviour:
- Reset (asynchronous, immediate on rst=1): both sync stages, read_ptr, read_ptr_gray, rd_valid and underflow go to 0. Resulting outputs: empty=1, rd_count=0, almost_empty=1.
- Synchroniser:
  - Two-flop chain clocked by read_clk: sync1 <= write_ptr_gray; sync2 <= sync1.
  - No logic between the stages.
  - wptr_bin = gray-to-binary(sync2), where bit[PTR_W-1] = g[PTR_W-1] and bit[i] = bit[i+1] ^ g[i].
- Latency: a write-pointer change appears in wptr_bin after the 2nd read_clk rising edge following the change.
- Pop acceptance: pop = rd_en && !empty. On pop, read_ptr <= read_ptr + 1 (mod 2^PTR_W).
- read_ptr_gray:
  - Registered in the same edge as read_ptr, as bin2gray(next read_ptr), where bin2gray(x) = x ^ (x >> 1).
  - Never driven combinationally, so it is glitch-free across the domain crossing.
- Flag and count logic (combinational from registered state):
  - empty = (read_ptr == wptr_bin).
  - rd_count = wptr_bin - read_ptr, PTR_W-bit modulo arithmetic.
  - almost_empty = (rd_count <= AE_THRESH).
- Empty timing:
  - Empty updates in the same cycle read_ptr changes, so the last pop raises empty immediately.
  - Deassertion of empty lags the write side by 2 to 3 read_clk cycles. This is pessimistic and safe.
- rd_valid <= pop, i.e. a 1-cycle pulse on the edge after acceptance, aligned to registered memory output.
- Underflow:
  - rd_en && empty sets underflow <= 1. The pointer does not move and rd_valid stays 0.
  - Underflow clears only on rst.
- Wrap-around: read_ptr 2^PTR_W-1 -> 0. With PTR_W=4, read_ptr_gray goes 1000 -> 0000. rd_count arithmetic remains correct across the wrap.
- Pop on every cycle is legal; throughput is 1 entry/cycle while !empty.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight rd_valid pulse is cancelled.

Test Plan:
- Reset: assert rst mid-clock -> immediately read_ptr=0, read_ptr_gray=0, empty=1, rd_count=0, almost_empty=1, rd_valid=0, underflow=0.
- Sync latency: write_ptr_gray 0000->0001 between edges -> empty stays 1 for one edge, drops after the 2nd edge; rd_count=1, almost_empty=1.
- Pop: with rd_count=1, rd_en=1 for one cycle -> read_ptr=1, read_ptr_gray=0001, empty=1 in the same cycle, rd_valid=1 for exactly the next cycle.
- Underflow: empty=1, rd_en=1 -> read_ptr unchanged, rd_valid=0, underflow=1 and stays 1 after rd_en drops, until rst.
- Wrap: write_ptr_gray walks to 0000 after a 15-entry lap, pop 15 entries from read_ptr=1 -> read_ptr sequence 1..15,0. Gray reads 1000 at 15 and 0000 at 0. rd_count decrements 15..0; almost_empty asserts when rd_count<=2.
- Burst: rd_count=5, rd_en held high -> exactly 5 pops on consecutive cycles, rd_valid high 5 cycles, empty=1 afterwards, underflow=1 only if rd_en remains high once empty.
